// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the priority / round-robin encoder family.
package encoder_pkg;

  localparam logic ENC_FIXED = 1'b0;
  localparam logic ENC_RR    = 1'b1;
  localparam int   ENC_MAX_N = 64;

  // Index of the set bit of a one-hot vector (zero-extended to ENC_MAX_N).
  function automatic int onehot_to_idx(input logic [ENC_MAX_N-1:0] onehot);
    int idx;
    idx = 0;
    for (int i = 0; i < ENC_MAX_N; i++) begin
      if (onehot[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/encoder_pri_rr_if.sv
// Request/result handshake bundle for encoder_pri_rr; slave = encoder side.
interface encoder_pri_rr_if #(
  parameter int N = 8
) ();
  localparam int W = $clog2(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic         out_none;
  logic         out_multi;

  modport slave (
    input  in_valid, in_req, out_ready,
    output in_ready, out_valid, out_idx, out_onehot, out_none, out_multi
  );

  modport master (
    output in_valid, in_req, out_ready,
    input  in_ready, out_valid, out_idx, out_onehot, out_none, out_multi
  );
endinterface

// File: rtl/encoder_pri_find.sv
// Combinational lowest-set-bit finder: index, one-hot grant and any-bit-set flag.
module encoder_pri_find #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         found
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        onehot[i] = 1'b1;
        idx       = W'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_pri_rr.sv
// Registered N-to-log2(N) encoder with fixed or round-robin priority and
// valid/ready handshakes; one result register, latency 1, throughput 1/cycle.
module encoder_pri_rr
  import encoder_pkg::*;
#(
  parameter int   N         = 8,
  parameter logic RR        = ENC_FIXED,
  parameter logic MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  encoder_pri_rr_if.slave   bus
);

  localparam int W = $clog2(N);

  logic         out_valid_reg;
  logic [W-1:0] out_idx_reg;
  logic [N-1:0] out_onehot_reg;
  logic         out_none_reg;
  logic         out_multi_reg;

  logic [N-1:0] find_req;
  logic [N-1:0] f_onehot;
  logic [W-1:0] f_idx;
  logic         f_found;
  logic [W-1:0] sel_idx;
  logic [N-1:0] sel_onehot;
  logic         req_multi;
  logic         accept;

  assign bus.in_ready = !out_valid_reg || bus.out_ready;
  assign accept       = bus.in_valid && (!out_valid_reg || bus.out_ready);

  encoder_pri_find #(.N(N), .W(W)) u_find (
    .req    (find_req),
    .idx    (f_idx),
    .onehot (f_onehot),
    .found  (f_found)
  );

  // Any bit left after removing the winner means more than one was set.
  assign req_multi = |(find_req & ~f_onehot);

  generate
    if (RR == ENC_RR) begin : g_rr
      logic [W-1:0] ptr_reg;

      // Rotate so that bit ptr lands on the finder's highest-priority position.
      always_comb begin
        find_req = '0;
        for (int p = 0; p < N; p++) begin
          if (ptr_reg == W'(p)) begin
            for (int j = 0; j < N; j++) find_req[j] = bus.in_req[(j + p) % N];
          end
        end
      end

      always_comb begin
        sel_onehot = '0;
        sel_idx    = '0;
        for (int p = 0; p < N; p++) begin
          if (ptr_reg == W'(p)) begin
            for (int j = 0; j < N; j++) begin
              sel_onehot[(j + p) % N] = f_onehot[j];
              if (f_idx == W'(j)) sel_idx = W'((j + p) % N);
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ptr_reg <= '0;
        end else if (accept && f_found) begin
          ptr_reg <= (sel_idx == W'(N - 1)) ? '0 : sel_idx + W'(1);
        end
      end
    end else if (MSB_FIRST) begin : g_msb
      always_comb begin
        find_req = '0;
        for (int i = 0; i < N; i++) find_req[i] = bus.in_req[N - 1 - i];
      end

      always_comb begin
        sel_onehot = '0;
        sel_idx    = '0;
        for (int j = 0; j < N; j++) begin
          sel_onehot[N - 1 - j] = f_onehot[j];
          if (f_idx == W'(j)) sel_idx = W'(N - 1 - j);
        end
      end
    end else begin : g_lsb
      assign find_req   = bus.in_req;
      assign sel_onehot = f_onehot;
      assign sel_idx    = f_idx;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_idx_reg    <= '0;
      out_onehot_reg <= '0;
      out_none_reg   <= 1'b0;
      out_multi_reg  <= 1'b0;
    end else if (accept) begin
      out_valid_reg  <= 1'b1;
      out_idx_reg    <= f_found ? sel_idx : '0;
      out_onehot_reg <= sel_onehot;
      out_none_reg   <= !f_found;
      out_multi_reg  <= req_multi;
    end else if (bus.out_ready) begin
      out_valid_reg  <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_reg;
  assign bus.out_idx    = out_idx_reg;
  assign bus.out_onehot = out_onehot_reg;
  assign bus.out_none   = out_none_reg;
  assign bus.out_multi  = out_multi_reg;

endmodule

// File: tb/tb_encoder_pri_rr.sv
// Bench for encoder_pri_rr: four configurations share one stimulus stream and
// are compared each cycle against a search-based reference model.
module tb_encoder_pri_rr;
  import encoder_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_req;

  always #5 clk = ~clk;

  encoder_pri_rr_if #(.N(8)) if0 ();
  encoder_pri_rr_if #(.N(8)) if1 ();
  encoder_pri_rr_if #(.N(8)) if2 ();
  encoder_pri_rr_if #(.N(5)) if3 ();

  assign if0.in_valid = in_valid;  assign if0.out_ready = out_ready;  assign if0.in_req = in_req;
  assign if1.in_valid = in_valid;  assign if1.out_ready = out_ready;  assign if1.in_req = in_req;
  assign if2.in_valid = in_valid;  assign if2.out_ready = out_ready;  assign if2.in_req = in_req;
  assign if3.in_valid = in_valid;  assign if3.out_ready = out_ready;  assign if3.in_req = in_req[4:0];

  encoder_pri_rr #(.N(8), .RR(ENC_FIXED), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(if0));
  encoder_pri_rr #(.N(8), .RR(ENC_FIXED), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(if1));
  encoder_pri_rr #(.N(8), .RR(ENC_RR),    .MSB_FIRST(1'b0)) u_rr8 (.clk(clk), .rst(rst), .bus(if2));
  encoder_pri_rr #(.N(5), .RR(ENC_RR),    .MSB_FIRST(1'b1)) u_rr5 (.clk(clk), .rst(rst), .bus(if3));

  logic       o_valid [4];
  logic       o_ready [4];
  logic       o_none  [4];
  logic       o_multi [4];
  logic [2:0] o_idx   [4];
  logic [7:0] o_oh    [4];

  assign o_valid[0] = if0.out_valid;  assign o_ready[0] = if0.in_ready;  assign o_none[0] = if0.out_none;
  assign o_multi[0] = if0.out_multi;  assign o_idx[0]   = if0.out_idx;   assign o_oh[0]   = if0.out_onehot;
  assign o_valid[1] = if1.out_valid;  assign o_ready[1] = if1.in_ready;  assign o_none[1] = if1.out_none;
  assign o_multi[1] = if1.out_multi;  assign o_idx[1]   = if1.out_idx;   assign o_oh[1]   = if1.out_onehot;
  assign o_valid[2] = if2.out_valid;  assign o_ready[2] = if2.in_ready;  assign o_none[2] = if2.out_none;
  assign o_multi[2] = if2.out_multi;  assign o_idx[2]   = if2.out_idx;   assign o_oh[2]   = if2.out_onehot;
  assign o_valid[3] = if3.out_valid;  assign o_ready[3] = if3.in_ready;  assign o_none[3] = if3.out_none;
  assign o_multi[3] = if3.out_multi;  assign o_idx[3]   = if3.out_idx;   assign o_oh[3]   = {3'b000, if3.out_onehot};

  // Reference model state, one slot per configuration.
  int   nn   [4] = '{8, 8, 8, 5};
  bit   rrm  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  bit   msbm [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  bit         e_valid [4];
  int         e_idx   [4];
  logic [7:0] e_oh    [4];
  bit         e_none  [4];
  bit         e_multi [4];
  int         e_ptr   [4];

  int checks   = 0;
  int failures = 0;
  bit checking = 1'b0;

  function automatic int pick(int n, bit rr, bit msb, int p, logic [7:0] req);
    if (rr) begin
      for (int k = 0; k < n; k++) if (req[(p + k) % n]) return (p + k) % n;
    end else if (msb) begin
      for (int b = n - 1; b >= 0; b--) if (req[b]) return b;
    end else begin
      for (int b = 0; b < n; b++) if (req[b]) return b;
    end
    return -1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check current outputs, advance the model by one edge, then step past the edge.
  task automatic cycle();
    logic [7:0] r;
    int         s;
    bit         acc;
    #1;
    if (checking) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("u%0d_in_ready", k), 32'(o_ready[k]), 32'(!e_valid[k] || out_ready));
        chk($sformatf("u%0d_valid", k), 32'(o_valid[k]), 32'(e_valid[k]));
        chk($sformatf("u%0d_idx", k), 32'(o_idx[k]), 32'(e_idx[k]));
        chk($sformatf("u%0d_onehot", k), 32'(o_oh[k]), 32'(e_oh[k]));
        chk($sformatf("u%0d_none", k), 32'(o_none[k]), 32'(e_none[k]));
        chk($sformatf("u%0d_multi", k), 32'(o_multi[k]), 32'(e_multi[k]));
      end
    end
    acc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r   = in_req & (8'hFF >> (8 - nn[k]));
      acc = in_valid && (!e_valid[k] || out_ready);
      if (rst) begin
        e_valid[k] = 1'b0; e_idx[k] = 0; e_oh[k] = 8'h00;
        e_none[k]  = 1'b0; e_multi[k] = 1'b0; e_ptr[k] = 0;
      end else if (acc) begin
        s          = pick(nn[k], rrm[k], msbm[k], e_ptr[k], r);
        e_valid[k] = 1'b1;
        e_none[k]  = (s < 0);
        e_idx[k]   = (s < 0) ? 0 : s;
        e_oh[k]    = (s < 0) ? 8'h00 : 8'(1 << s);
        e_multi[k] = ($countones(r) > 1);
        if (rrm[k] && s >= 0) e_ptr[k] = (s + 1) % nn[k];
      end else if (out_ready) begin
        e_valid[k] = 1'b0;
      end
    end
    if (acc && !rst)
      $display("txn req=%02h lsb=%0d msb=%0d rr8=%0d rr5=%0d none=%0d",
               in_req, e_idx[0], e_idx[1], e_idx[2], e_idx[3], e_none[0]);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_req = 8'h00; out_ready = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    checking = 1'b1;
    cycle();
    chk("reset_valid", 32'(o_valid[2]), 32'd0);
    chk("reset_idx", 32'(o_idx[2]), 32'd0);

    // One-hot sweep must match the legacy 8x3 encoder.
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_req = 8'(1 << i);
      cycle();
      chk($sformatf("sweep_idx%0d", i), 32'(o_idx[0]), 32'(i));
      chk($sformatf("sweep_legacy%0d", i), 32'(onehot_to_idx(64'(o_oh[0]))), 32'(i));
    end

    in_req = 8'b0110_1000;
    cycle();
    chk("multi_lsb_idx", 32'(o_idx[0]), 32'd3);
    chk("multi_lsb_onehot", 32'(o_oh[0]), 32'h08);
    chk("multi_lsb_flag", 32'(o_multi[0]), 32'd1);
    chk("multi_msb_idx", 32'(o_idx[1]), 32'd6);

    // Round-robin wrap, then an empty request that must not move the pointer.
    do_reset();
    in_valid = 1'b1; in_req = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk($sformatf("rr_wrap%0d", i), 32'(o_idx[2]), 32'(i % 8));
    end
    in_req = 8'h00;
    cycle();
    chk("rr_none_flag", 32'(o_none[2]), 32'd1);
    chk("rr_none_idx", 32'(o_idx[2]), 32'd0);
    in_req = 8'hFF;
    cycle();
    chk("rr_ptr_kept", 32'(o_idx[2]), 32'd2);

    do_reset();
    in_valid = 1'b1; in_req = 8'b0001_0001;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("rr5_%0d", i), 32'(o_idx[3]), (i % 2 == 1) ? 32'd4 : 32'd0);
    end

    // Backpressure then same-cycle drain and accept.
    in_req = 8'h24;
    cycle();
    out_ready = 1'b0; in_req = 8'h81;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("bp_ready%0d", i), 32'(o_ready[0]), 32'd0);
      chk($sformatf("bp_hold%0d", i), 32'(o_idx[0]), 32'd2);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_release_valid", 32'(o_valid[0]), 32'd1);
    chk("bp_release_lsb", 32'(o_idx[0]), 32'd0);
    chk("bp_release_msb", 32'(o_idx[1]), 32'd7);

    // Reset while holding a result with ptr=5.
    do_reset();
    in_valid = 1'b1; in_req = 8'hFF;
    repeat (5) cycle();
    chk("pre_rst_idx", 32'(o_idx[2]), 32'd4);
    rst = 1'b1; out_ready = 1'b0;
    cycle();
    chk("mid_rst_valid", 32'(o_valid[2]), 32'd0);
    chk("mid_rst_onehot", 32'(o_oh[2]), 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    cycle();
    chk("post_rst_rr", 32'(o_idx[2]), 32'd0);

    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       in_req = 8'h00;
        1:       in_req = 8'(1 << $urandom_range(0, 7));
        default: in_req = 8'($urandom);
      endcase
      cycle();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
